// File: rtl/tfaw_window_tracker.sv
// Per-rank four-activate window tracker: each rank keeps the last four ACT
// ages and blocks a fifth ACT until the oldest one has aged out of tFAW.
module tfaw_window_tracker #(
    parameter int                      CMD_TYPE_WIDTH        = 3,
    parameter logic [CMD_TYPE_WIDTH-1:0] ACT_BITS            = 3'b010,
    parameter int                      NUM_RANKS             = 2,
    parameter int                      RANK_WIDTH            = 1,
    parameter int                      TIME_CONSTRAINT_WIDTH = 8,
    parameter int                      tFAW                  = 36
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       cmd_valid,
    input  logic [CMD_TYPE_WIDTH-1:0]                  sel_cmd,
    input  logic [RANK_WIDTH-1:0]                      sel_rank,
    output logic [NUM_RANKS-1:0]                       act_allowed,
    output logic [NUM_RANKS*TIME_CONSTRAINT_WIDTH-1:0] faw_wait,
    output logic [NUM_RANKS*3-1:0]                     win_count,
    output logic                                       tfaw_violation
);

    localparam int TW = TIME_CONSTRAINT_WIDTH;
    localparam logic [TW-1:0] TFAW_LOAD = TW'(tFAW);

    logic [TW-1:0]        cnt_q [NUM_RANKS][4];
    logic [TW-1:0]        cnt_d [NUM_RANKS][4];
    logic [3:0]           vld_q [NUM_RANKS];
    logic [3:0]           vld_d [NUM_RANKS];
    logic                 viol_q;
    logic                 viol_d;
    logic [NUM_RANKS-1:0] act_hit;

    always_comb begin
        act_hit = '0;
        for (int r = 0; r < NUM_RANKS; r++) begin
            act_hit[r] = cmd_valid && (sel_cmd == ACT_BITS) &&
                         (32'(sel_rank) == r);
        end
    end

    // Shift uses pre-decrement values, so an entry may expire on the same
    // edge a new one enters.
    always_comb begin
        logic [TW-1:0] sh_cnt [4];
        logic [3:0]    sh_vld;
        viol_d = viol_q;
        for (int r = 0; r < NUM_RANKS; r++) begin
            for (int e = 0; e < 4; e++) begin
                sh_cnt[e] = cnt_q[r][e];
            end
            sh_vld = vld_q[r];
            if (act_hit[r]) begin
                if (vld_q[r][3]) begin
                    viol_d = 1'b1;
                end
                for (int e = 3; e > 0; e--) begin
                    sh_cnt[e] = cnt_q[r][e-1];
                end
                sh_cnt[0] = TFAW_LOAD;
                sh_vld    = {vld_q[r][2:0], 1'b1};
            end
            for (int e = 0; e < 4; e++) begin
                cnt_d[r][e] = (sh_cnt[e] == '0) ? '0 : sh_cnt[e] - TW'(1);
                vld_d[r][e] = sh_vld[e] && (cnt_d[r][e] != '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_q <= 1'b0;
            for (int r = 0; r < NUM_RANKS; r++) begin
                vld_q[r] <= '0;
                for (int e = 0; e < 4; e++) begin
                    cnt_q[r][e] <= '0;
                end
            end
        end else begin
            viol_q <= viol_d;
            for (int r = 0; r < NUM_RANKS; r++) begin
                vld_q[r] <= vld_d[r];
                for (int e = 0; e < 4; e++) begin
                    cnt_q[r][e] <= cnt_d[r][e];
                end
            end
        end
    end

    always_comb begin
        act_allowed = '0;
        faw_wait    = '0;
        win_count   = '0;
        for (int r = 0; r < NUM_RANKS; r++) begin
            act_allowed[r] = ~vld_q[r][3];
            faw_wait[r*TW +: TW] = vld_q[r][3] ? cnt_q[r][3] : '0;
            win_count[r*3 +: 3] = {2'b00, vld_q[r][0]} + {2'b00, vld_q[r][1]} +
                                  {2'b00, vld_q[r][2]} + {2'b00, vld_q[r][3]};
        end
    end

    assign tfaw_violation = viol_q;

endmodule

// File: tb/tb_tfaw_window_tracker.sv
// Directed bench for tfaw_window_tracker with a reference window model feeding
// an expected-output scoreboard, plus spot checks of key timing points.
module tb_tfaw_window_tracker;

    localparam int TFAW = 36;
    localparam logic [2:0] ACT = 3'b010;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [2:0]  sel_cmd;
    logic [0:0]  sel_rank;
    logic [1:0]  act_allowed;
    logic [15:0] faw_wait;
    logic [5:0]  win_count;
    logic        tfaw_violation;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  aa;
        logic [15:0] fw;
        logic [5:0]  wc;
        logic        viol;
    } exp_t;

    exp_t sb[$];

    int m_cnt [2][4];
    bit m_vld [2][4];
    bit m_viol;

    tfaw_window_tracker #(
        .CMD_TYPE_WIDTH(3), .ACT_BITS(3'b010), .NUM_RANKS(2), .RANK_WIDTH(1),
        .TIME_CONSTRAINT_WIDTH(8), .tFAW(TFAW)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .sel_cmd(sel_cmd),
        .sel_rank(sel_rank), .act_allowed(act_allowed), .faw_wait(faw_wait),
        .win_count(win_count), .tfaw_violation(tfaw_violation)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_viol = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int e = 0; e < 4; e++) begin
                m_cnt[r][e] = 0;
                m_vld[r][e] = 1'b0;
            end
    endtask

    task automatic model_step(input bit v, input logic [2:0] c, input int rk);
        for (int r = 0; r < 2; r++) begin
            if (v && c == ACT && rk == r) begin
                if (m_vld[r][3]) m_viol = 1'b1;
                for (int e = 3; e > 0; e--) begin
                    m_cnt[r][e] = m_cnt[r][e-1];
                    m_vld[r][e] = m_vld[r][e-1];
                end
                m_cnt[r][0] = TFAW;
                m_vld[r][0] = 1'b1;
            end
            for (int e = 0; e < 4; e++) begin
                if (m_cnt[r][e] > 0) m_cnt[r][e]--;
                if (m_cnt[r][e] == 0) m_vld[r][e] = 1'b0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x = '0;
        for (int r = 0; r < 2; r++) begin
            int n = 0;
            for (int e = 0; e < 4; e++) n += int'(m_vld[r][e]);
            x.wc[r*3 +: 3] = 3'(n);
            x.aa[r]        = !m_vld[r][3];
            x.fw[r*8 +: 8] = m_vld[r][3] ? 8'(m_cnt[r][3]) : 8'd0;
        end
        x.viol = m_viol;
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one command for one edge; expected post-edge outputs go to the
    // scoreboard and are popped once the DUT has taken the edge.
    task automatic tick(input bit v, input logic [2:0] c, input int rk);
        exp_t e;
        cmd_valid = v;
        sel_cmd   = c;
        sel_rank  = 1'(rk);
        model_step(v, c, rk);
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        sel_cmd   = 3'b000;
        sel_rank  = 1'b0;
        e = sb.pop_front();
        chk("sb_act_allowed", 32'(act_allowed), 32'(e.aa));
        chk("sb_faw_wait", 32'(faw_wait), 32'(e.fw));
        chk("sb_win_count", 32'(win_count), 32'(e.wc));
        chk("sb_violation", 32'(tfaw_violation), 32'(e.viol));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 3'b000, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_act_allowed", 32'(act_allowed), 32'h3);
        chk("rst_win_count", 32'(win_count), 32'h0);
        chk("rst_faw_wait", 32'(faw_wait), 32'h0);
        chk("rst_violation", 32'(tfaw_violation), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        sel_cmd   = 3'b000;
        sel_rank  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // 1: idle after reset
        idle(10);
        chk("t1_act_allowed", 32'(act_allowed), 32'h3);
        chk("t1_win_count", 32'(win_count), 32'h0);

        // 2: four ACTs 4 apart, fifth accepted once the window has aged out
        for (int i = 0; i <= 36; i++) begin
            tick((i % 4 == 0) && (i <= 12 || i == 36), ACT, 0);
            if (i == 12) begin
                chk("t2_blocked", 32'(act_allowed[0]), 32'h0);
                chk("t2_count4", 32'(win_count[2:0]), 32'h4);
                chk("t2_wait23", 32'(faw_wait[7:0]), 32'd23);
            end
            if (i == 34) chk("t2_still_blocked", 32'(act_allowed[0]), 32'h0);
            if (i == 35) chk("t2_unblocked", 32'(act_allowed[0]), 32'h1);
        end
        chk("t2_no_violation", 32'(tfaw_violation), 32'h0);
        do_reset();

        // 3: early fifth ACT sets the sticky violation
        for (int i = 0; i <= 20; i++) tick((i % 4 == 0), ACT, 0);
        chk("t3_violation", 32'(tfaw_violation), 32'h1);
        chk("t3_count4", 32'(win_count[2:0]), 32'h4);
        idle(40);
        chk("t3_sticky", 32'(tfaw_violation), 32'h1);
        do_reset();

        // 4: interleaved ranks block and unblock independently
        for (int i = 0; i <= 37; i++) begin
            tick((i <= 14) && (i % 2 == 0), ACT, (i % 4 == 2) ? 1 : 0);
            if (i == 12) chk("t4_r0_only", 32'(act_allowed), 32'h2);
            if (i == 14) chk("t4_both", 32'(act_allowed), 32'h0);
            if (i == 35) chk("t4_r0_free", 32'(act_allowed), 32'h1);
            if (i == 36) chk("t4_r1_wait", 32'(act_allowed), 32'h1);
            if (i == 37) chk("t4_r1_free", 32'(act_allowed), 32'h3);
        end
        do_reset();

        // 5: back-to-back ACTs, new ACT right after the oldest ages out
        for (int i = 0; i <= 36; i++) begin
            tick((i <= 3) || (i == 36), ACT, 0);
            if (i == 3)  chk("t5_full", 32'(win_count[2:0]), 32'h4);
            if (i == 34) chk("t5_full_34", 32'(win_count[2:0]), 32'h4);
            if (i == 35) chk("t5_expire", 32'(win_count[2:0]), 32'h3);
        end
        chk("t5_no_violation", 32'(tfaw_violation), 32'h0);
        idle(3);
        do_reset();

        // 6: non-ACT traffic only ages counters; async reset clears mid-window
        for (int i = 0; i < 4; i++) tick(1'b1, ACT, 0);
        tick(1'b1, 3'b001, 0);
        chk("t6_nonact_a", 32'(win_count[2:0]), 32'h4);
        tick(1'b1, 3'b011, 0);
        tick(1'b1, 3'b110, 1);
        tick(1'b0, ACT, 1);
        chk("t6_nonact_b", 32'(win_count), 32'h4);
        tick(1'b1, 3'b000, 0);
        tick(1'b1, 3'b111, 0);
        chk("t6_full_before_rst", 32'(act_allowed[0]), 32'h0);
        rst = 1'b1;
        #1;
        chk("t6_async_allowed", 32'(act_allowed), 32'h3);
        chk("t6_async_count", 32'(win_count), 32'h0);
        chk("t6_async_wait", 32'(faw_wait), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b1, ACT, 0);
        chk("t6_after_rst", 32'(win_count[2:0]), 32'h1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
